// File: rtl/sar_controller.sv
// Successive-approximation ADC control FSM.
// Samples ain onto vip and walks a binary-search trial code on vin, MSB first.
// Each trial is held for SETTLE_CYCLES idle cycles before one comp_req pulse.
// The result bit is taken when comp_done arrives.
// A missing comp_done aborts the conversion after TIMEOUT_CYCLES WAIT cycles.
//
// Handshake: comp_req is a single-cycle request (initiator side). The
// comparator answers with comp_done=1 for one cycle, and comp_result is
// valid in that same cycle. comp_done is only acted on in WAIT, so a
// stale or early comp_done seen in IDLE/SETTLE has no effect.
module sar_controller #(
    parameter int N_BITS         = 12,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_BITS-1:0] ain,
    output logic [N_BITS-1:0] vip,
    output logic [N_BITS-1:0] vin,
    output logic              comp_req,
    input  logic              comp_result,
    input  logic              comp_done,
    output logic              busy,
    output logic [N_BITS-1:0] data_out,
    output logic              data_valid,
    output logic              timeout_err,
    output logic [1:0]        dbg_state
);

    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int ST_W  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    localparam logic [N_BITS-1:0] MSB_CODE = {1'b1, {(N_BITS-1){1'b0}}};

    logic [1:0]        state_q,       state_d;
    logic [N_BITS-1:0] vip_q,         vip_d;
    logic [N_BITS-1:0] vin_q,         vin_d;
    logic [IDX_W-1:0]  idx_q,         idx_d;
    logic [ST_W-1:0]   settle_q,      settle_d;
    logic [TO_W-1:0]   to_q,          to_d;
    logic              comp_req_q,    comp_req_d;
    logic              busy_q,        busy_d;
    logic [N_BITS-1:0] data_out_q,    data_out_d;
    logic              data_valid_q,  data_valid_d;
    logic              timeout_err_q, timeout_err_d;

    // Helpers: trial code with the current bit decided, next index, next wait count.
    logic [N_BITS-1:0] vin_decided;
    logic [IDX_W-1:0]  idx_m1;
    logic [TO_W-1:0]   to_inc;

    // Next-state and output computation for the SAR sequence.
    always_comb begin
        state_d       = state_q;
        vip_d         = vip_q;
        vin_d         = vin_q;
        idx_d         = idx_q;
        settle_d      = settle_q;
        to_d          = to_q;
        comp_req_d    = 1'b0;
        busy_d        = busy_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        timeout_err_d = timeout_err_q;

        vin_decided         = vin_q;
        vin_decided[idx_q]  = comp_result;
        idx_m1              = idx_q - IDX_W'(1);
        to_inc              = to_q + TO_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vip_d         = ain;
                    vin_d         = MSB_CODE;
                    idx_d         = IDX_W'(N_BITS - 1);
                    settle_d      = ST_W'(SETTLE_CYCLES);
                    busy_d        = 1'b1;
                    timeout_err_d = 1'b0;
                    state_d       = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - ST_W'(1);
                end else begin
                    comp_req_d = 1'b1;
                    to_d       = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (comp_done) begin
                    if (idx_q != '0) begin
                        vin_d         = vin_decided;
                        vin_d[idx_m1] = 1'b1;
                        idx_d         = idx_m1;
                        settle_d      = ST_W'(SETTLE_CYCLES);
                        state_d       = S_SETTLE;
                    end else begin
                        // vin keeps the final code after completion.
                        vin_d        = vin_decided;
                        data_out_d   = vin_decided;
                        data_valid_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = S_IDLE;
                    end
                end else begin
                    to_d = to_inc;
                    if (to_inc == TO_W'(TIMEOUT_CYCLES)) begin
                        timeout_err_d = 1'b1;
                        busy_d        = 1'b0;
                        state_d       = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            vip_q         <= '0;
            vin_q         <= '0;
            idx_q         <= '0;
            settle_q      <= '0;
            to_q          <= '0;
            comp_req_q    <= 1'b0;
            busy_q        <= 1'b0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vip_q         <= vip_d;
            vin_q         <= vin_d;
            idx_q         <= idx_d;
            settle_q      <= settle_d;
            to_q          <= to_d;
            comp_req_q    <= comp_req_d;
            busy_q        <= busy_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign vip         = vip_q;
    assign vin         = vin_q;
    assign comp_req    = comp_req_q;
    assign busy        = busy_q;
    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sar_controller.sv
// Testbench for sar_controller: a comparator model, a start driver, and a
// scoreboard whose monitor pops expected results on data_valid or timeout.
module tb_sar_controller;

    localparam int N   = 12;
    localparam int S   = 2;
    localparam int T   = 15;
    localparam int LAT = N * (S + 3);
    localparam int TO_LAT = S + 1 + T;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] ain = '0;
    logic [N-1:0] vip, vin, data_out;
    logic         comp_req, comp_result, comp_done;
    logic         busy, data_valid, timeout_err;
    logic [1:0]   dbg_state;

    sar_controller #(.N_BITS(N), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .start(start), .ain(ain),
        .vip(vip), .vin(vin), .comp_req(comp_req),
        .comp_result(comp_result), .comp_done(comp_done),
        .busy(busy), .data_out(data_out), .data_valid(data_valid),
        .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard queues: one entry per accepted start.
    logic [N-1:0] exp_q[$];     // expected data_out at the end of the conversion
    logic [N-1:0] ain_q[$];     // sampled input, drives the trial-code model
    bit           kind_q[$];    // 1 = conversion expected to time out
    int           start_q[$];   // cycle count after the accepting edge
    logic [N-1:0] last_good = '0;

    int cmp_mode = 0;           // 0 prompt, 1 noisy (comp_done junk outside WAIT), 2 silent

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: k-th trial of a binary search for code a.
    function automatic logic [N-1:0] ref_trial(input logic [N-1:0] a, input int k);
        int code;
        int tr;
        code = 0;
        for (int j = 0; j < k; j++) begin
            tr = code + (1 << (N - 1 - j));
            if (int'(a) >= tr) code = tr;
        end
        return N'(code + (1 << (N - 1 - k)));
    endfunction

    function automatic logic [N-1:0] ref_convert(input logic [N-1:0] a);
        int code;
        int tr;
        code = 0;
        for (int j = 0; j < N; j++) begin
            tr = code + (1 << (N - 1 - j));
            if (int'(a) >= tr) code = tr;
        end
        return N'(code);
    endfunction

    // Comparator model, driven on the falling edge.
    bit pending = 0;
    always @(negedge clk) begin
        if (!rst) begin
            pending     = 0;
            comp_done   = 1'b0;
            comp_result = 1'b0;
        end else begin
            comp_done   = 1'b0;
            comp_result = (vip >= vin);
            if (cmp_mode != 2 && pending) begin
                comp_done = 1'b1;
            end else if (cmp_mode == 1 && !comp_req && busy) begin
                comp_done   = 1'b1;
                comp_result = !(vip >= vin);
            end
            pending = comp_req && (cmp_mode != 2);
        end
    end

    // Monitor: trial codes, completions, timeouts, pulse widths.
    int pulse_cnt = 0;
    bit te_prev   = 0;
    bit dv_prev   = 0;
    always @(negedge clk) begin
        if (!rst) begin
            pulse_cnt = 0;
            te_prev   = 0;
            dv_prev   = 0;
        end else begin
            if (dv_prev) check("dv_width", data_valid, 1'b0);
            if (comp_req) begin
                if (ain_q.size() == 0 || pulse_cnt >= N) begin
                    check("spurious_req", comp_req, 1'b0);
                end else begin
                    check("trial_vin", vin, ref_trial(ain_q[0], pulse_cnt));
                end
                pulse_cnt++;
            end
            if (data_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_dv", exp_q.size(), 1);
                end else begin
                    check("dv_kind", kind_q[0], 1'b0);
                    check("data_out", data_out, exp_q[0]);
                    check("latency", cyc - start_q[0], LAT);
                    check("req_count", pulse_cnt, N);
                    check("busy_done", busy, 1'b0);
                    check("vin_final", vin, exp_q[0]);
                    void'(exp_q.pop_front());
                    void'(ain_q.pop_front());
                    void'(kind_q.pop_front());
                    void'(start_q.pop_front());
                end
                pulse_cnt = 0;
            end
            if (timeout_err && !te_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_to", exp_q.size(), 1);
                end else begin
                    check("to_kind", kind_q[0], 1'b1);
                    check("to_data_hold", data_out, exp_q[0]);
                    check("to_latency", cyc - start_q[0], TO_LAT);
                    check("to_busy", busy, 1'b0);
                    check("to_req", comp_req, 1'b0);
                    check("to_req_count", pulse_cnt, 1);
                    void'(exp_q.pop_front());
                    void'(ain_q.pop_front());
                    void'(kind_q.pop_front());
                    void'(start_q.pop_front());
                end
                pulse_cnt = 0;
            end
            te_prev = timeout_err;
            dv_prev = data_valid;
        end
    end

    // Driver: issue a start right after a falling edge and record the expectation.
    task automatic do_start(input logic [N-1:0] a, input bit expect_timeout);
        ain   = a;
        start = 1'b1;
        ain_q.push_back(a);
        kind_q.push_back(expect_timeout);
        start_q.push_back(cyc + 1);
        if (expect_timeout) begin
            exp_q.push_back(last_good);
        end else begin
            last_good = ref_convert(a);
            exp_q.push_back(last_good);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        ain   = N'($urandom);
        check("busy_start", busy, 1'b1);
        check("vip_sample", vip, a);
    endtask

    task automatic flush_sb();
        exp_q.delete();
        ain_q.delete();
        kind_q.delete();
        start_q.delete();
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        if (exp_q.size() != 0) flush_sb();
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_vip"}, vip, '0);
        check({tag, "_vin"}, vin, '0);
        check({tag, "_data_out"}, data_out, '0);
        check({tag, "_comp_req"}, comp_req, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_data_valid"}, data_valid, 1'b0);
        check({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    // Watchdog.
    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Main stimulus sequence.
    initial begin
        logic [N-1:0] bounds[3];
        int seen;
        bounds[0] = 12'h000;
        bounds[1] = 12'hFFF;
        bounds[2] = 12'h800;

        repeat (3) @(negedge clk);
        check_zero("rst");
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Nominal conversion with starts pulsed while busy.
        do_start(12'hA5C, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1; ain = 12'h3C3;
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        start = 1'b1; ain = 12'h7E1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);
        check("nominal_hold", data_out, 12'hA5C);

        // Boundary codes.
        foreach (bounds[i]) begin
            do_start(bounds[i], 1'b0);
            wait_done(200);
        end

        // Junk comp_done outside WAIT must be ignored.
        cmp_mode = 1;
        repeat (2) begin
            do_start(N'($urandom), 1'b0);
            wait_done(200);
        end
        cmp_mode = 0;

        // Start in the data_valid cycle is accepted.
        do_start(N'($urandom), 1'b0);
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            @(negedge clk);
            if (data_valid) seen = 1;
        end
        check("dv_seen", seen, 1);
        do_start(N'($urandom), 1'b0);
        wait_done(200);

        // Timeout: comparator silent.
        cmp_mode = 2;
        do_start(N'($urandom), 1'b1);
        wait_done(200);
        repeat (3) @(negedge clk);
        check("to_sticky", timeout_err, 1'b1);
        cmp_mode = 0;
        do_start(N'($urandom), 1'b0);
        check("to_clear", timeout_err, 1'b0);
        wait_done(200);

        // Asynchronous reset while bit index 6 is being tried.
        do_start(N'($urandom), 1'b0);
        seen = 0;
        for (int i = 0; i < 200 && seen < 6; i++) begin
            @(negedge clk);
            if (comp_req) seen++;
        end
        #2;
        rst = 1'b0;
        #1;
        check_zero("midrst");
        flush_sb();
        last_good = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        do_start(12'h123, 1'b0);
        wait_done(200);
        check("post_rst_data", data_out, 12'h123);

        // Randomized conversions.
        repeat (10) begin
            cmp_mode = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_start(N'($urandom), 1'b0);
            wait_done(200);
        end
        cmp_mode = 0;

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_controller.md
Name: sar_controller

Overview:
- Successive-approximation control FSM that drives the ideal comparator model in the ADC experiments.
- It samples the input code and holds it on vip, then steps a binary-search trial code on vin.
- For each trial it issues one comparison request, consumes comp_result/comp_done, and builds the output word MSB-first.
- It sits between the stimulus/sample source and the comparator, and is the initiator for the comparator's responder side.

Parameters:
N_BITS, 12, converter resolution; width of ain, vip, vin and data_out
SETTLE_CYCLES, 2, idle cycles a new trial code is held on vin before comp_req (0 allowed)
TIMEOUT_CYCLES, 15, max consecutive WAIT cycles without comp_done before abort (>=1)

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  reset, asynchronous, active-low
start  input  1  conversion request, sampled only in IDLE
ain  input  N_BITS  input code to convert, captured on accepted start
vip  output  N_BITS  held sample to comparator
vin  output  N_BITS  current trial (DAC) code to comparator
comp_req  output  1  one-cycle comparison request
comp_result  input  1  1 = vip >= vin
comp_done  input  1  comparator result valid
busy  output  1  conversion in progress
data_out  output  N_BITS  last completed conversion result
data_valid  output  1  one-cycle pulse, data_out updated
timeout_err  output  1  sticky; last conversion aborted on timeout

Behaviour:
- Reset (rst low, any time, asynchronous):
  - State goes to IDLE.
  - vip, vin, data_out, comp_req, busy, data_valid and timeout_err all go to 0.
  - Internal counters clear.
  - A conversion in flight is discarded with no data_valid.
- All outputs are registered.
- States: IDLE, SETTLE, WAIT.
- IDLE:
  - start=1 at a posedge accepts a conversion:
    - vip<=ain
    - vin<=1<<(N_BITS-1)
    - bit index<=N_BITS-1
    - settle count<=SETTLE_CYCLES
    - busy<=1
    - timeout_err<=0
    - go to SETTLE
  - start=0: stay in IDLE.
- SETTLE:
  - count>0: decrement.
  - count==0: comp_req<=1, timeout count<=0, go to WAIT.
  - SETTLE therefore lasts SETTLE_CYCLES+1 cycles.
  - comp_done is ignored in SETTLE.
- WAIT:
  - comp_req is high only during the first WAIT cycle; it is cleared at the next posedge.
  - comp_done=1 at a posedge (decide edge):
    - Current bit is kept if comp_result=1, cleared otherwise.
    - If index>0: set bit index-1 of vin, decrement index, reload settle count, go to SETTLE.
    - If index==0: data_out<=final code (with bit 0 decided), data_valid<=1, busy<=0, go to IDLE.
  - comp_done=0: increment timeout count.
    - On reaching TIMEOUT_CYCLES: timeout_err<=1, busy<=0, comp_req<=0, go to IDLE.
    - data_out is unchanged and data_valid stays 0.
- Latency: with a comparator that raises comp_done one cycle after seeing comp_req, each bit takes SETTLE_CYCLES+3 cycles.
  - data_valid is high in the cycle after posedge N_BITS*(SETTLE_CYCLES+3) counted from the start edge.
  - Defaults: 60.
- start while busy is ignored; no queuing.
- start in the cycle data_valid is high is accepted, because the FSM is already in IDLE.
- vin keeps the final code after completion; vip holds the sample until the next accepted start.
- data_out holds its value until the next successful completion.
- Exactly N_BITS comp_req pulses per successful conversion.

Test Plan:
- Reset: assert rst low mid-run, then release -> all outputs 0, state IDLE, no comp_req until start.
- Nominal: defaults, ain=12'hA5C, bench comparator registers comp_done one cycle after comp_req -> 12 comp_req pulses; vin sequence 800,C00,A00,B00,A80,A40,A60,A50,A58,A5C,A5E,A5D; data_out=12'hA5C; data_valid one cycle at edge 60+1; busy low after.
- Boundaries: ain=12'h000 -> vin 800,400,...,001, data_out=000. ain=12'hFFF -> data_out=FFF. ain=12'h800 -> data_out=800.
- Handshake: comp_done held high during SETTLE is ignored; start pulsed at cycles 5 and 30 during busy is ignored; start in the data_valid cycle starts a new conversion.
- Timeout: comparator never responds -> after first comp_req, 15 WAIT cycles, then timeout_err=1, busy=0, no data_valid, data_out unchanged; next start clears timeout_err and converts normally.
- Reset mid-operation: rst low while index=6 -> immediate zeroed outputs; following start with ain=12'h123 -> data_out=12'h123.
